// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, sequencer state encoding and the
// opcode classification bundle used by the decode stage.
package riscv_pkg;

   // RV32I base opcodes (instruction bits [6:0])
   localparam logic [6:0] OP_R     = 7'h33;
   localparam logic [6:0] OP_I     = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_S     = 7'h23;
   localparam logic [6:0] OP_B     = 7'h63;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;

   // Sequencer states; encodings 5 and 6 are unused and recover to FETCH
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_e;

   // Per-opcode attributes the sequencer branches on
   typedef struct packed {
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_jump;
      logic is_legal;
   } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational RV32I opcode classifier.
module op_classify
   import riscv_pkg::*;
(
   input  logic [6:0] i_opcode,
   output op_class_t  o_class
);

   // Map each base opcode to its attributes; anything else is illegal
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a bit unassigned, which would otherwise infer a latch.
      o_class = '0;
      unique case (i_opcode)
         OP_R, OP_I, OP_LUI, OP_AUIPC: o_class.is_legal = 1'b1;
         OP_LOAD: begin
            o_class.is_load  = 1'b1;
            o_class.is_legal = 1'b1;
         end
         OP_S: begin
            o_class.is_store = 1'b1;
            o_class.is_legal = 1'b1;
         end
         OP_B: begin
            o_class.is_branch = 1'b1;
            o_class.is_legal  = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            o_class.is_jump  = 1'b1;
            o_class.is_legal = 1'b1;
         end
         default: o_class = '0;
      endcase
   end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP state for illegal opcodes and a retired-instruction counter.
module core_seq
   import riscv_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [6:0]  i_opcode,
   input  logic        i_br_taken,
   input  logic        i_imem_ack,
   input  logic        i_dmem_ack,
   output logic        o_imem_req,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic        o_pc_sel,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic        o_regwrite,
   output logic        o_trap,
   output logic [2:0]  o_state,
   output logic [31:0] o_instret
);

   state_e      state_q, state_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [31:0] instret_q, instret_d;
   logic [6:0]  cls_opcode;
   op_class_t   cls;
   logic        retire;

   // In DECODE the live opcode drives the legality decision; afterwards only
   // the registered copy is used so the instruction register may change.
   assign cls_opcode = (state_q == ST_DECODE) ? i_opcode : opcode_q;

   op_classify u_classify (
      .i_opcode (cls_opcode),
      .o_class  (cls)
   );

   // State, latched opcode and retire counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         instret_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         instret_q <= instret_d;
      end
   end

   // Next-state and strobe decode from the registered state
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      retire     = 1'b0;
      o_imem_req = 1'b0;
      o_ir_we    = 1'b0;
      o_pc_we    = 1'b0;
      o_pc_sel   = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_regwrite = 1'b0;
      o_trap     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            // Reset forces FETCH, so gating here keeps the request low
            // while reset is held and ignores acks for aborted fetches.
            if (!i_rst) begin
               o_imem_req = 1'b1;
               if (i_imem_ack) begin
                  o_ir_we = 1'b1;
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            opcode_d = i_opcode;
            state_d  = cls.is_legal ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            if (cls.is_branch) begin
               o_pc_we  = 1'b1;
               o_pc_sel = i_br_taken;
               retire   = 1'b1;
               state_d  = ST_FETCH;
            end else if (cls.is_load || cls.is_store) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = cls.is_store;
            if (i_dmem_ack) begin
               if (cls.is_store) begin
                  o_pc_we = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            o_regwrite = 1'b1;
            o_pc_we    = 1'b1;
            o_pc_sel   = cls.is_jump;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_TRAP: begin
            o_trap = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase
      // Free-running count; wraps silently at 2^32
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   assign o_state   = state_q;
   assign o_instret = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq.
module tb_core_seq;

   logic        i_clk;
   logic        i_rst;
   logic [6:0]  i_opcode;
   logic        i_br_taken;
   logic        i_imem_ack;
   logic        i_dmem_ack;
   logic        o_imem_req;
   logic        o_ir_we;
   logic        o_pc_we;
   logic        o_pc_sel;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic        o_regwrite;
   logic        o_trap;
   logic [2:0]  o_state;
   logic [31:0] o_instret;

   int          checks;
   int          errors;
   int          rw_cnt;
   int          pcwe_cnt;
   int          strobe_cnt;
   logic [31:0] exp_ret;

   core_seq dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_opcode   (i_opcode),
      .i_br_taken (i_br_taken),
      .i_imem_ack (i_imem_ack),
      .i_dmem_ack (i_dmem_ack),
      .o_imem_req (o_imem_req),
      .o_ir_we    (o_ir_we),
      .o_pc_we    (o_pc_we),
      .o_pc_sel   (o_pc_sel),
      .o_dmem_req (o_dmem_req),
      .o_dmem_we  (o_dmem_we),
      .o_regwrite (o_regwrite),
      .o_trap     (o_trap),
      .o_state    (o_state),
      .o_instret  (o_instret)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Pulse counters sampled on the falling edge, away from the active edge
   always @(negedge i_clk) begin
      if (!i_rst) begin
         rw_cnt     += int'(o_regwrite);
         pcwe_cnt   += int'(o_pc_we);
         strobe_cnt += int'(o_imem_req | o_ir_we | o_pc_we | o_dmem_req |
                            o_dmem_we | o_regwrite);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Runs one instruction from FETCH back to FETCH. mem_n is the number of
   // MEM cycles (ack on the last one); live opcode is scrambled after DECODE.
   task automatic run_op(input string tag, input logic [6:0] op, input logic br,
                         input int mem_n, input int exp_cyc, input int exp_rw,
                         input logic exp_sel, input logic exp_dwe);
      int   n;
      int   mem_seen;
      int   rw0;
      int   pc0;
      logic sel_seen;
      logic dwe_seen;
      logic ir_seen;
      n = 0; mem_seen = 0; sel_seen = 1'b0; dwe_seen = 1'b0; ir_seen = 1'b0;
      rw0 = rw_cnt; pc0 = pcwe_cnt;
      i_br_taken = br;
      i_imem_ack = 1'b1;
      do begin
         i_opcode   = (n <= 1) ? op : ~op;
         i_dmem_ack = (o_state == 3'd3) && (mem_seen == mem_n - 1);
         #1;
         if (n == 0) ir_seen = o_ir_we;
         if (o_pc_we) sel_seen = o_pc_sel;
         if (o_state == 3'd3) begin
            mem_seen++;
            dwe_seen = o_dmem_we;
         end
         step();
         n++;
      end while (o_state != 3'd0 && n < 20);
      i_imem_ack = 1'b0;
      i_dmem_ack = 1'b0;
      exp_ret    = exp_ret + 32'd1;
      check({tag, " cycles"},   32'(n),              32'(exp_cyc));
      check({tag, " ir_we"},    32'(ir_seen),        32'd1);
      check({tag, " regwrite"}, 32'(rw_cnt - rw0),   32'(exp_rw));
      check({tag, " pc_we"},    32'(pcwe_cnt - pc0), 32'd1);
      check({tag, " pc_sel"},   32'(sel_seen),       32'(exp_sel));
      check({tag, " mem_cyc"},  32'(mem_seen),       32'(mem_n));
      check({tag, " dmem_we"},  32'(dwe_seen),       32'(exp_dwe));
      check({tag, " instret"},  o_instret,           exp_ret);
   endtask

   initial begin
      int s0;
      int rw0;
      checks = 0; errors = 0; rw_cnt = 0; pcwe_cnt = 0; strobe_cnt = 0;
      exp_ret = 32'd0;
      i_rst = 1'b1; i_opcode = '0; i_br_taken = 1'b0;
      i_imem_ack = 1'b1; i_dmem_ack = 1'b1;

      // Reset state, with acks driven to show they are ignored
      step(); step();
      check("rst state",    32'(o_state),    32'd0);
      check("rst instret",  o_instret,       32'd0);
      check("rst trap",     32'(o_trap),     32'd0);
      check("rst imem_req", 32'(o_imem_req), 32'd0);
      check("rst ir_we",    32'(o_ir_we),    32'd0);
      check("rst strobes",  32'({o_pc_we, o_dmem_req, o_dmem_we, o_regwrite}), 32'd0);
      i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
      i_rst = 1'b0;
      #1;
      check("post-rst imem_req", 32'(o_imem_req), 32'd1);

      //      tag      opcode  br    mem cyc rw sel   dwe
      run_op("ADD",   7'h33, 1'b0, 0,  4,  1, 1'b0, 1'b0);
      run_op("BEQ_T", 7'h63, 1'b1, 0,  3,  0, 1'b1, 1'b0);
      run_op("BNE_N", 7'h63, 1'b0, 0,  3,  0, 1'b0, 1'b0);
      run_op("LW_W3", 7'h03, 1'b0, 3,  7,  1, 1'b0, 1'b0);
      run_op("SW",    7'h23, 1'b1, 1,  4,  0, 1'b0, 1'b1);
      run_op("LUI",   7'h37, 1'b1, 0,  4,  1, 1'b0, 1'b0);
      run_op("JAL",   7'h6F, 1'b0, 0,  4,  1, 1'b1, 1'b0);
      run_op("JALR",  7'h67, 1'b0, 0,  4,  1, 1'b1, 1'b0);
      run_op("AUIPC", 7'h17, 1'b1, 0,  4,  1, 1'b0, 1'b0);
      run_op("ADDI",  7'h13, 1'b1, 0,  4,  1, 1'b0, 1'b0);
      run_op("LW",    7'h03, 1'b1, 1,  5,  1, 1'b0, 1'b0);
      run_op("SW_W2", 7'h23, 1'b0, 2,  5,  0, 1'b0, 1'b1);

      // Counter wrap: preset to all-ones while idling in FETCH
      force dut.instret_q = 32'hFFFF_FFFF;
      step();
      release dut.instret_q;
      exp_ret = 32'hFFFF_FFFF;
      check("preset instret", o_instret, exp_ret);
      run_op("WRAP", 7'h33, 1'b0, 0, 4, 1, 1'b0, 1'b0);
      check("wrapped to zero", o_instret, 32'd0);

      // Reset during MEM with a simultaneous ack
      i_opcode = 7'h03; i_imem_ack = 1'b1;
      step(); step(); step();
      i_imem_ack = 1'b0;
      check("mem before rst", 32'(o_state), 32'd3);
      rw0 = rw_cnt;
      i_dmem_ack = 1'b1;
      i_rst = 1'b1;
      #1;
      check("rst mem dmem_req", 32'(o_dmem_req), 32'd0);
      check("rst mem state",    32'(o_state),    32'd0);
      step();
      i_rst = 1'b0;
      step();
      check("late ack ignored", 32'(o_state),  32'd0);
      check("no regwrite",      32'(rw_cnt - rw0), 32'd0);
      check("rst mem instret",  o_instret,     32'd0);
      i_dmem_ack = 1'b0;

      // Illegal opcode traps and sticks, ignoring acks
      i_opcode = 7'h7F; i_imem_ack = 1'b1;
      step(); step();
      check("trap state", 32'(o_state), 32'd7);
      check("trap flag",  32'(o_trap),  32'd1);
      s0 = strobe_cnt;
      i_dmem_ack = 1'b1;
      repeat (20) step();
      check("trap held state", 32'(o_state), 32'd7);
      check("trap held flag",  32'(o_trap),  32'd1);
      check("trap no strobes", 32'(strobe_cnt - s0), 32'd0);
      i_rst = 1'b1;
      #1;
      check("trap cleared", 32'(o_trap),  32'd0);
      check("trap rst state", 32'(o_state), 32'd0);
      i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
      step();
      i_rst = 1'b0;
      #1;
      check("restart imem_req", 32'(o_imem_req), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
